// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared types and constants for the
// data-memory bridge and its watchdog.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] STRB_READ = 4'b1111;
  localparam int WDT_W = 16;

endpackage

// File: rtl/wdt_counter.sv
// wdt_counter: transaction watchdog; counts enabled cycles
// since the last clear and flags the cycle that hits the limit.
module wdt_counter
  import dmem_bridge_pkg::*;
#(
  parameter int W = WDT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  // cycle counter, restarted at the start of each transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  // the limit-th enabled cycle is the last one allowed
  assign expired = enable & (count == limit - W'(1));

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: MEM-stage to valid/ready data-bus bridge with
// pipeline stall, full-word read return and a watchdog.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic            MemWrite,
  input  logic [3:0]      MemWriteSelect,
  input  logic            MemReadM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic [XLEN-1:0] bus_addr,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic            bus_rsp_valid,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            bus_err
);

  state_t state;
  state_t nextState;

  logic access;
  logic isStore;
  logic latchReq;
  logic capture;
  logic timeoutHit;
  logic wdtClear;
  logic wdtEnable;
  logic wdtExpired;

  logic [XLEN-1:0] reqAddr;
  logic [XLEN-1:0] reqWdata;
  logic [3:0]      reqStrb;
  logic            reqWe;

  assign access  = MemWrite | MemReadM;
  assign isStore = MemWrite & ~MemReadM;

  wdt_counter #(
    .W(WDT_W)
  ) uWdt (
    .clk    (clk),
    .reset  (reset),
    .clear  (wdtClear),
    .enable (wdtEnable),
    .limit  (WDT_W'(TIMEOUT)),
    .expired(wdtExpired)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // next state and per-cycle control
  always_comb begin
    nextState     = state;
    latchReq      = 1'b0;
    capture       = 1'b0;
    timeoutHit    = 1'b0;
    wdtClear      = 1'b0;
    wdtEnable     = 1'b0;
    bus_req_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          latchReq  = 1'b1;
          wdtClear  = 1'b1;
          nextState = REQ;
        end
      end
      REQ: begin
        bus_req_valid = 1'b1;
        wdtEnable     = 1'b1;
        if (wdtExpired) begin
          timeoutHit = 1'b1;
          nextState  = DONE;
        end else if (bus_req_ready) begin
          nextState = WAIT;
        end
      end
      WAIT: begin
        wdtEnable = 1'b1;
        if (bus_rsp_valid) begin
          capture   = 1'b1;
          nextState = DONE;
        end else if (wdtExpired) begin
          timeoutHit = 1'b1;
          nextState  = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign StallM = access & (state != DONE);

  // request registers, loaded only when leaving IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      reqAddr  <= '0;
      reqWdata <= '0;
      reqStrb  <= '0;
      reqWe    <= 1'b0;
    end else if (latchReq) begin
      reqAddr  <= {ALUResultM[XLEN-1:2], 2'b00};
      reqWdata <= WriteDataM;
      reqStrb  <= isStore ? MemWriteSelect : STRB_READ;
      reqWe    <= isStore;
    end
  end

  // read-data capture and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ReadDataM <= '0;
      bus_err   <= 1'b0;
    end else if (capture) begin
      ReadDataM <= bus_rdata;
    end else if (timeoutHit) begin
      ReadDataM <= '0;
      bus_err   <= 1'b1;
    end
  end

  assign bus_addr  = reqAddr;
  assign bus_wdata = reqWdata;
  assign bus_wstrb = reqStrb;
  assign bus_we    = reqWe;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: randomized self-checking bench for dmem_bridge
// against a cycle-count reference model.
module tb_dmem_bridge;

  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [XLEN-1:0] ALUResultM = '0;
  logic [XLEN-1:0] WriteDataM = '0;
  logic            MemWrite = 1'b0;
  logic [3:0]      MemWriteSelect = '0;
  logic            MemReadM = 1'b0;
  logic [XLEN-1:0] ReadDataM;
  logic            StallM;
  logic            bus_req_valid;
  logic            bus_req_ready = 1'b0;
  logic [XLEN-1:0] bus_addr;
  logic            bus_we;
  logic [XLEN-1:0] bus_wdata;
  logic [3:0]      bus_wstrb;
  logic            bus_rsp_valid = 1'b0;
  logic [XLEN-1:0] bus_rdata = '0;
  logic            bus_err;

  int passCount = 0;
  int totalCount = 0;
  bit errModel = 1'b0;

  always #5 clk = ~clk;

  dmem_bridge #(
    .XLEN   (XLEN),
    .TIMEOUT(TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ALUResultM    (ALUResultM),
    .WriteDataM    (WriteDataM),
    .MemWrite      (MemWrite),
    .MemWriteSelect(MemWriteSelect),
    .MemReadM      (MemReadM),
    .ReadDataM     (ReadDataM),
    .StallM        (StallM),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_wdata     (bus_wdata),
    .bus_wstrb     (bus_wstrb),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata),
    .bus_err       (bus_err)
  );

  // Reference: the slave holds ready low for d REQ cycles and
  // answers r cycles after the handshake. The access costs one
  // IDLE cycle plus (d+1)+(r+1) bus cycles, capped by TO.
  function automatic void predict(
    input int d, input int r, input logic [31:0] rdata,
    output int stall, output logic [31:0] rd, output bit to,
    output int hs);
    int n;
    n = (d + 1) + (r + 1);
    hs = (d + 1 <= TO) ? 1 : 0;
    if (n <= TO) begin
      stall = n + 1;
      rd = rdata;
      to = 1'b0;
    end else begin
      stall = TO + 1;
      rd = '0;
      to = 1'b1;
    end
  endfunction

  // Drives one MEM-stage access and plays the slave; returns
  // what was observed up to and including the DONE cycle.
  task automatic runAccess(
    input bit rdIn, input bit wrIn,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic [3:0] strb, input int d, input int r,
    input logic [31:0] rdata, input bit junk,
    output int stall, output int hs,
    output logic [31:0] rdObs, output logic errObs,
    output int fieldErrs, output logic doneValid);
    int reqCyc;
    int waitCyc;
    bit inWait;
    bit hsNow;
    logic [31:0] expAddr;
    logic expWe;
    logic [3:0] expStrb;
    expAddr = {addr[31:2], 2'b00};
    expWe = wrIn & ~rdIn;
    expStrb = expWe ? strb : 4'hF;
    stall = 0;
    hs = 0;
    fieldErrs = 0;
    rdObs = '0;
    errObs = 1'b0;
    doneValid = 1'b0;
    reqCyc = 0;
    waitCyc = 0;
    inWait = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      ALUResultM = addr;
      WriteDataM = wdata;
      MemWrite = wrIn;
      MemReadM = rdIn;
      MemWriteSelect = strb;
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_rdata = $urandom;
      hsNow = 1'b0;
      if (bus_req_valid) begin
        if (bus_addr !== expAddr || bus_we !== expWe ||
            bus_wdata !== wdata || bus_wstrb !== expStrb)
          fieldErrs++;
        if (reqCyc == d) begin
          bus_req_ready = 1'b1;
          hs++;
          hsNow = 1'b1;
        end
        if (junk)
          bus_rsp_valid = 1'($urandom_range(0, 1));
        reqCyc++;
      end else if (inWait) begin
        if (waitCyc == r) begin
          bus_rsp_valid = 1'b1;
          bus_rdata = rdata;
        end
        waitCyc++;
      end
      if (hsNow) inWait = 1'b1;
      #1;
      if (!StallM) begin
        rdObs = ReadDataM;
        errObs = bus_err;
        doneValid = bus_req_valid;
        break;
      end
      stall++;
    end
  endtask

  // Idle cycles with no access; counts cycles showing activity.
  task automatic idleCycles(input int n, output int busy);
    busy = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      MemWrite = 1'b0;
      MemReadM = 1'b0;
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      #1;
      if (bus_req_valid || StallM) busy++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    MemReadM = 1'b0;
    MemWrite = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    totalCount++;
    if (bus_req_valid !== 1'b0 || bus_we !== 1'b0)
      $display("FAIL reset_ctl valid=%b we=%b want 0 0",
               bus_req_valid, bus_we);
    else passCount++;
    totalCount++;
    if (bus_addr !== '0 || bus_wdata !== '0 || bus_wstrb !== '0)
      $display("FAIL reset_req addr=%h wdata=%h strb=%h want 0",
               bus_addr, bus_wdata, bus_wstrb);
    else passCount++;
    totalCount++;
    if (ReadDataM !== '0 || bus_err !== 1'b0)
      $display("FAIL reset_rsp rd=%h err=%b want 0 0",
               ReadDataM, bus_err);
    else passCount++;
    totalCount++;
    if (StallM !== 1'b0)
      $display("FAIL reset_stall_idle got %b want 0", StallM);
    else passCount++;
    MemReadM = 1'b1;
    #1;
    totalCount++;
    if (StallM !== 1'b1)
      $display("FAIL reset_stall_access got %b want 1", StallM);
    else passCount++;
    @(posedge clk);
    #1;
    totalCount++;
    if (bus_req_valid !== 1'b0)
      $display("FAIL reset_hold got valid=%b want 0", bus_req_valid);
    else passCount++;
    @(negedge clk);
    reset = 1'b0;
    MemReadM = 1'b0;
    errModel = 1'b0;
  endtask

  task automatic test_load();
    int stall, hs, fe, eStall, eHs;
    logic [31:0] rd, eRd;
    logic err, dv;
    bit to;
    predict(0, 0, 32'hDEADBEEF, eStall, eRd, to, eHs);
    runAccess(1'b1, 1'b0, 32'h1006, 32'h5555_0000, 4'h3, 0, 0,
              32'hDEADBEEF, 1'b0, stall, hs, rd, err, fe, dv);
    errModel |= to;
    totalCount++;
    if (stall !== eStall)
      $display("FAIL load_stall got %0d want %0d", stall, eStall);
    else passCount++;
    totalCount++;
    if (rd !== eRd)
      $display("FAIL load_data got %h want %h", rd, eRd);
    else passCount++;
    totalCount++;
    if (bus_addr !== 32'h1004 || bus_wstrb !== 4'hF || bus_we !== 1'b0)
      $display("FAIL load_req addr=%h strb=%h we=%b want 1004 f 0",
               bus_addr, bus_wstrb, bus_we);
    else passCount++;
    totalCount++;
    if (hs !== eHs || fe !== 0 || err !== errModel)
      $display("FAIL load_bus hs=%0d fe=%0d err=%b want %0d 0 %b",
               hs, fe, err, eHs, errModel);
    else passCount++;
  endtask

  task automatic test_store_hold();
    int stall, hs, fe, eStall, eHs;
    logic [31:0] rd, eRd;
    logic err, dv;
    bit to;
    predict(4, 0, 32'h0BAD_F00D, eStall, eRd, to, eHs);
    runAccess(1'b0, 1'b1, 32'h2002, 32'h00AB_0000, 4'b0100, 4, 0,
              32'h0BAD_F00D, 1'b1, stall, hs, rd, err, fe, dv);
    errModel |= to;
    totalCount++;
    if (stall !== eStall)
      $display("FAIL store_stall got %0d want %0d", stall, eStall);
    else passCount++;
    totalCount++;
    if (fe !== 0)
      $display("FAIL store_hold unstable cycles=%0d want 0", fe);
    else passCount++;
    totalCount++;
    if (bus_we !== 1'b1 || bus_wstrb !== 4'b0100 ||
        bus_wdata !== 32'h00AB_0000)
      $display("FAIL store_req we=%b strb=%b wdata=%h want 1 0100 00ab0000",
               bus_we, bus_wstrb, bus_wdata);
    else passCount++;
    totalCount++;
    if (hs !== eHs || rd !== eRd)
      $display("FAIL store_rsp hs=%0d rd=%h want %0d %h",
               hs, rd, eHs, eRd);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    int s1, h1, f1, s2, h2, f2, eS1, eH1, eS2, eH2;
    logic [31:0] r1, r2, eR1, eR2;
    logic e1, e2, dv1, dv2;
    bit to1, to2;
    predict(0, 1, 32'h1111_2222, eS1, eR1, to1, eH1);
    predict(1, 0, 32'h3333_4444, eS2, eR2, to2, eH2);
    runAccess(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 1,
              32'h1111_2222, 1'b1, s1, h1, r1, e1, f1, dv1);
    runAccess(1'b0, 1'b1, 32'h0000_0081, 32'hCAFE_0000, 4'b1100, 1, 0,
              32'h3333_4444, 1'b1, s2, h2, r2, e2, f2, dv2);
    errModel |= to1 | to2;
    totalCount++;
    if (h1 !== eH1 || h2 !== eH2)
      $display("FAIL b2b_requests got %0d,%0d want %0d,%0d",
               h1, h2, eH1, eH2);
    else passCount++;
    totalCount++;
    if (dv1 !== 1'b0 || f2 !== 0)
      $display("FAIL b2b_dup done_valid=%b fe2=%0d want 0 0", dv1, f2);
    else passCount++;
    totalCount++;
    if (s1 !== eS1 || s2 !== eS2)
      $display("FAIL b2b_stall got %0d,%0d want %0d,%0d",
               s1, s2, eS1, eS2);
    else passCount++;
    totalCount++;
    if (r1 !== eR1 || r2 !== eR2)
      $display("FAIL b2b_data got %h,%h want %h,%h", r1, r2, eR1, eR2);
    else passCount++;
  endtask

  task automatic test_random();
    int stall, hs, fe, eStall, eHs, d, r, sel, busy;
    logic [31:0] rd, eRd, rdata, addr, wdata;
    logic [3:0] strb;
    logic err, dv;
    bit to;
    for (int i = 0; i < 20; i++) begin
      sel = $urandom_range(1, 3);
      d = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      rdata = $urandom;
      addr = $urandom;
      wdata = $urandom;
      strb = 4'($urandom);
      predict(d, r, rdata, eStall, eRd, to, eHs);
      runAccess(sel[0], sel[1], addr, wdata, strb, d, r, rdata, 1'b1,
                stall, hs, rd, err, fe, dv);
      errModel |= to;
      totalCount++;
      if (stall !== eStall || rd !== eRd || hs !== eHs ||
          fe !== 0 || err !== errModel || dv !== 1'b0)
        $display("FAIL rand_%0d stall=%0d rd=%h hs=%0d fe=%0d err=%b want %0d %h %0d 0 %b",
                 i, stall, rd, hs, fe, err, eStall, eRd, eHs, errModel);
      else passCount++;
      idleCycles($urandom_range(0, 2), busy);
      totalCount++;
      if (busy !== 0)
        $display("FAIL rand_idle_%0d busy=%0d want 0", i, busy);
      else passCount++;
    end
  endtask

  task automatic test_rsp_at_timeout();
    int stall, hs, fe, eStall, eHs;
    logic [31:0] rd, eRd;
    logic err, dv;
    bit to;
    predict(0, TO - 2, 32'hA5A5_0F0F, eStall, eRd, to, eHs);
    runAccess(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 0, TO - 2,
              32'hA5A5_0F0F, 1'b0, stall, hs, rd, err, fe, dv);
    errModel |= to;
    totalCount++;
    if (stall !== eStall || rd !== eRd)
      $display("FAIL rsp_at_to stall=%0d rd=%h want %0d %h",
               stall, rd, eStall, eRd);
    else passCount++;
    totalCount++;
    if (err !== errModel)
      $display("FAIL rsp_at_to_err got %b want %b", err, errModel);
    else passCount++;
    predict(3, TO - 5, 32'h7777_8888, eStall, eRd, to, eHs);
    runAccess(1'b1, 1'b0, 32'h304, 32'h0, 4'h0, 3, TO - 5,
              32'h7777_8888, 1'b1, stall, hs, rd, err, fe, dv);
    errModel |= to;
    totalCount++;
    if (stall !== eStall || rd !== eRd || err !== errModel)
      $display("FAIL rsp_at_to2 stall=%0d rd=%h err=%b want %0d %h %b",
               stall, rd, err, eStall, eRd, errModel);
    else passCount++;
  endtask

  task automatic test_timeout();
    int stall, hs, fe, eStall, eHs;
    logic [31:0] rd, eRd;
    logic err, dv;
    bit to;
    predict(0, 200, 32'hFFFF_FFFF, eStall, eRd, to, eHs);
    runAccess(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 0, 200,
              32'hFFFF_FFFF, 1'b0, stall, hs, rd, err, fe, dv);
    errModel |= to;
    totalCount++;
    if (stall !== eStall || rd !== eRd)
      $display("FAIL to_wait stall=%0d rd=%h want %0d %h",
               stall, rd, eStall, eRd);
    else passCount++;
    totalCount++;
    if (err !== errModel)
      $display("FAIL to_wait_err got %b want %b", err, errModel);
    else passCount++;
    predict(200, 0, 32'h1234_5678, eStall, eRd, to, eHs);
    runAccess(1'b0, 1'b1, 32'h408, 32'h0102_0304, 4'hF, 200, 0,
              32'h1234_5678, 1'b1, stall, hs, rd, err, fe, dv);
    errModel |= to;
    totalCount++;
    if (stall !== eStall || rd !== eRd || hs !== eHs)
      $display("FAIL to_req stall=%0d rd=%h hs=%0d want %0d %h %0d",
               stall, rd, hs, eStall, eRd, eHs);
    else passCount++;
  endtask

  task automatic test_err_sticky();
    int stall, hs, fe, eStall, eHs;
    logic [31:0] rd, eRd;
    logic err, dv;
    bit to;
    predict(1, 1, 32'h600D_600D, eStall, eRd, to, eHs);
    runAccess(1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 1, 1,
              32'h600D_600D, 1'b0, stall, hs, rd, err, fe, dv);
    errModel |= to;
    totalCount++;
    if (err !== errModel)
      $display("FAIL err_sticky got %b want %b", err, errModel);
    else passCount++;
    totalCount++;
    if (rd !== eRd || stall !== eStall)
      $display("FAIL err_sticky_data rd=%h stall=%0d want %h %0d",
               rd, stall, eRd, eStall);
    else passCount++;
  endtask

  task automatic test_reset_in_wait();
    int stall, hs, fe, eStall, eHs;
    logic [31:0] rd, eRd;
    logic err, dv;
    bit to;
    @(negedge clk);
    ALUResultM = 32'h600;
    MemReadM = 1'b1;
    MemWrite = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    MemReadM = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rdata = 32'h9999_AAAA;
    errModel = 1'b0;
    #1;
    totalCount++;
    if (bus_req_valid !== 1'b0 || StallM !== 1'b0)
      $display("FAIL rst_wait_idle valid=%b stall=%b want 0 0",
               bus_req_valid, StallM);
    else passCount++;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    #1;
    totalCount++;
    if (ReadDataM !== '0 || bus_err !== errModel)
      $display("FAIL rst_wait_drop rd=%h err=%b want 0 %b",
               ReadDataM, bus_err, errModel);
    else passCount++;
    totalCount++;
    if (bus_req_valid !== 1'b0)
      $display("FAIL rst_wait_novalid got %b want 0", bus_req_valid);
    else passCount++;
    predict(0, 0, 32'hBEEF_0001, eStall, eRd, to, eHs);
    runAccess(1'b1, 1'b0, 32'h604, 32'h0, 4'h0, 0, 0,
              32'hBEEF_0001, 1'b0, stall, hs, rd, err, fe, dv);
    errModel |= to;
    totalCount++;
    if (stall !== eStall || rd !== eRd || err !== errModel)
      $display("FAIL rst_wait_recover stall=%0d rd=%h err=%b want %0d %h %b",
               stall, rd, err, eStall, eRd, errModel);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_hold();
    test_back_to_back();
    test_random();
    test_rsp_at_timeout();
    test_timeout();
    test_err_sticky();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
